// File: rtl/flash_reader_pkg.sv
// rtl/flash_reader_pkg.sv - shared types and constants for the flash stream reader
// Purpose: sequencer state encoding and word geometry used by flash_stream_reader
//          and word_unpacker.
// Ports:   none (package).
package flash_reader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  // Wide enough to hold 0..BYTES_PER_WORD.
  localparam int CNT_W = 3;

endpackage

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - 32-bit word to MSB-first byte stream shifter
// Purpose: holds one flash word and hands its leading bytes out one at a time
//          over valid/ready, counting how many are still to be delivered.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   load                capture load_word / load_count this cycle
//   load_word[31:0]     word, first byte in [31:24]
//   load_count          number of bytes of the word to deliver (1..4)
//   enable              allows out_valid (owner gates it off on abort)
//   out_ready           consumer ready
//   out_valid           a byte is presented
//   out_data[7:0]       presented byte
//   fire                handshake completed this cycle
//   count               bytes still to deliver from the held word
module word_unpacker
  import flash_reader_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [31:0]      load_word,
  input  logic [CNT_W-1:0] load_count,
  input  logic             enable,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             fire,
  output logic [CNT_W-1:0] count
);

  logic [31:0]      shift_q;
  logic [CNT_W-1:0] count_q;

  assign out_valid = enable && (count_q != '0);
  assign fire      = out_valid && out_ready;
  assign out_data  = shift_q[31:24];
  assign count     = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= '0;
      count_q <= '0;
    end else if (load) begin
      shift_q <= load_word;
      count_q <= load_count;
    end else if (fire) begin
      shift_q <= {shift_q[23:0], 8'h00};
      count_q <= count_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/flash_stream_reader.sv
// rtl/flash_stream_reader.sv - region reader streaming flash bytes from spi_master words
// Purpose: given (start_addr, byte_count) issues successive 4-byte reads to
//          spi_master, acks each word and streams its bytes out MSB-first.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   start, start_addr, byte_count  transfer request, sampled only when idle
//   abort                        drop the current transfer
//   busy, done                   busy from accepted start until done; done is a 1-cycle pulse
//   out_valid/out_ready/out_data/out_last  byte stream, out_last on the final byte
//   spi_addr_buffer_free, spi_addr_en, spi_addr_data  address request to spi_master
//   spi_rd_data_available, spi_rd_ack, spi_rd_data    word return from spi_master
module flash_stream_reader
  import flash_reader_pkg::*;
#(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  byte_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  input  logic              spi_addr_buffer_free,
  output logic              spi_addr_en,
  output logic [ADDR_W-1:0] spi_addr_data,
  input  logic              spi_rd_data_available,
  output logic              spi_rd_ack,
  input  logic [31:0]       spi_rd_data
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q;
  logic [LEN_W-1:0]  remaining_q;
  logic              abort_q;   // abort seen while a word is still outstanding
  logic              load;
  logic              drain_en;
  logic              word_fire;
  logic [CNT_W-1:0]  load_count;
  logic [CNT_W-1:0]  word_count;

  // Kept outside the FSM block: word_fire depends on drain_en through the unpacker.
  assign drain_en   = (state_q == S_DRAIN) && !abort;
  assign load_count = (remaining_q >= LEN_W'(BYTES_PER_WORD)) ? CNT_W'(BYTES_PER_WORD)
                                                              : remaining_q[CNT_W-1:0];
  assign out_last      = out_valid && (remaining_q == LEN_W'(1));
  assign spi_addr_data = cur_addr_q;

  word_unpacker u_unpacker (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_word  (spi_rd_data),
    .load_count (load_count),
    .enable     (drain_en),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .fire       (word_fire),
    .count      (word_count)
  );

  always_comb begin
    state_d     = state_q;
    busy        = (state_q != S_IDLE);
    done        = 1'b0;
    spi_addr_en = 1'b0;
    spi_rd_ack  = 1'b0;
    load        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = (byte_count == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (spi_addr_buffer_free) begin
          spi_addr_en = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // An aborted read still waits for its word so spi_master is never left holding data.
        if (spi_rd_data_available) begin
          spi_rd_ack = 1'b1;
          if (abort || abort_q) begin
            state_d = S_DONE;
          end else begin
            load    = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (abort) begin
          state_d = S_DONE;
        end else if (word_fire && (word_count == CNT_W'(1))) begin
          state_d = (remaining_q == LEN_W'(1)) ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      abort_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          abort_q <= 1'b0;
          if (start) begin
            cur_addr_q  <= start_addr;
            remaining_q <= byte_count;
          end
        end
        S_WAIT: begin
          if (abort) abort_q <= 1'b1;
        end
        S_DRAIN: begin
          if (word_fire) begin
            remaining_q <= remaining_q - LEN_W'(1);
            // Address wraps modulo 2^ADDR_W by construction.
            if (word_count == CNT_W'(1)) cur_addr_q <= cur_addr_q + ADDR_W'(BYTES_PER_WORD);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_stream_reader.sv
// tb/tb_flash_stream_reader.sv - directed self-checking bench for flash_stream_reader
module tb_flash_stream_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [23:0] start_addr;
  logic [15:0] byte_count;
  logic        abort;
  logic        busy, done;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        spi_addr_buffer_free = 1'b1;
  logic        spi_addr_en;
  logic [23:0] spi_addr_data;
  logic        spi_rd_data_available = 1'b0;
  logic        spi_rd_ack;
  logic [31:0] spi_rd_data = 32'h0;

  flash_stream_reader #(.LEN_W(16), .ADDR_W(24)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .start                 (start),
    .start_addr            (start_addr),
    .byte_count            (byte_count),
    .abort                 (abort),
    .busy                  (busy),
    .done                  (done),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_data              (out_data),
    .out_last              (out_last),
    .spi_addr_buffer_free  (spi_addr_buffer_free),
    .spi_addr_en           (spi_addr_en),
    .spi_addr_data         (spi_addr_data),
    .spi_rd_data_available (spi_rd_data_available),
    .spi_rd_ack            (spi_rd_ack),
    .spi_rd_data           (spi_rd_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [23:0] addr_q[$];
  int          bytes_at_addr[$];
  logic [7:0]  byte_q[$];
  logic        last_q[$];
  int addr_cnt = 0, ack_cnt = 0, done_cnt = 0, byte_cnt = 0;
  int flight_err = 0, stab_err = 0;
  logic ov_seen = 1'b0;

  logic        en_seen = 1'b0, ack_seen = 1'b0;
  logic [23:0] en_addr = 24'h0;
  logic        pending = 1'b0;
  int          delay = 0;

  logic        rand_ready = 1'b0, ready_fixed = 1'b1;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // spi_master model, sampling half: observe DUT requests mid-cycle.
  always @(negedge clk) begin
    en_seen  = 1'b0;
    ack_seen = 1'b0;
    if (!reset) begin
      if (spi_rd_ack) begin
        ack_seen = 1'b1;
        ack_cnt++;
      end
      if (spi_addr_en) begin
        if (pending || spi_rd_data_available) flight_err++;
        en_seen = 1'b1;
        en_addr = spi_addr_data;
        addr_q.push_back(spi_addr_data);
        bytes_at_addr.push_back(byte_cnt);
        addr_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  // spi_master model, driving half: byte[a] = a[7:0].
  always @(posedge clk) begin
    #1;
    if (reset) begin
      pending = 1'b0;
      spi_rd_data_available = 1'b0;
    end else begin
      if (ack_seen) spi_rd_data_available = 1'b0;
      if (en_seen) begin
        pending = 1'b1;
        delay = $urandom_range(5, 40);
      end else if (pending) begin
        delay--;
        if (delay == 0) begin
          pending = 1'b0;
          spi_rd_data_available = 1'b1;
          spi_rd_data = {en_addr[7:0], en_addr[7:0] + 8'd1, en_addr[7:0] + 8'd2, en_addr[7:0] + 8'd3};
        end
      end
      spi_addr_buffer_free = ($urandom_range(0, 3) != 0);
    end
    out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : ready_fixed;
  end

  // Output stream monitor.
  always @(negedge clk) begin
    if (out_valid) ov_seen = 1'b1;
    if (prev_stall && !abort && !reset && (!out_valid || out_data !== prev_data)) stab_err++;
    if (out_valid && out_ready) begin
      byte_q.push_back(out_data);
      last_q.push_back(out_last);
      byte_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    addr_q.delete();
    bytes_at_addr.delete();
    byte_q.delete();
    last_q.delete();
    addr_cnt = 0; ack_cnt = 0; done_cnt = 0; byte_cnt = 0;
    flight_err = 0; stab_err = 0; ov_seen = 1'b0;
  endtask

  task automatic do_start(input logic [23:0] a, input logic [15:0] c);
    start_addr = a;
    byte_count = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check(tag, {31'd0, out_valid}, 32'd1);
  endtask

  logic [7:0] exp3 [6];
  int n;

  initial begin
    exp3 = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
    reset = 1'b1; start = 1'b0; start_addr = 24'h0; byte_count = 16'h0; abort = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_out_valid", {31'd0, out_valid}, 0);
    check("rst_out_last", {31'd0, out_last}, 0);
    check("rst_out_data", {24'd0, out_data}, 0);
    check("rst_addr_en", {31'd0, spi_addr_en}, 0);
    check("rst_rd_ack", {31'd0, spi_rd_ack}, 0);
    check("rst_addr_data", {8'd0, spi_addr_data}, 0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // 1: 0x100000, 5 bytes
    clear_logs();
    do_start(24'h100000, 16'd5);
    check("t1_busy_after_start", {31'd0, busy}, 1);
    wait_idle("t1_timeout", 2000);
    check("t1_addr_cnt", addr_cnt, 2);
    check("t1_addr0", {8'd0, addr_q[0]}, 32'h100000);
    check("t1_addr1", {8'd0, addr_q[1]}, 32'h100004);
    check("t1_acks", ack_cnt, 2);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_byte_cnt", byte_cnt, 5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t1_byte%0d", i), {24'd0, byte_q[i]}, i);
      check($sformatf("t1_last%0d", i), {31'd0, last_q[i]}, (i == 4) ? 1 : 0);
    end
    check("t1_flight", flight_err, 0);

    // 2: empty transfer
    clear_logs();
    do_start(24'h000123, 16'd0);
    check("t2_done_pulse", {31'd0, done}, 1);
    check("t2_busy_in_done", {31'd0, busy}, 1);
    tick();
    check("t2_done_low", {31'd0, done}, 0);
    check("t2_busy_low", {31'd0, busy}, 0);
    repeat (5) tick();
    check("t2_addr_cnt", addr_cnt, 0);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_valid_seen", {31'd0, ov_seen}, 0);

    // 3: unaligned start across the address wrap
    clear_logs();
    do_start(24'hFFFFFE, 16'd6);
    wait_idle("t3_timeout", 2000);
    check("t3_addr_cnt", addr_cnt, 2);
    check("t3_addr0", {8'd0, addr_q[0]}, 32'hFFFFFE);
    check("t3_addr1", {8'd0, addr_q[1]}, 32'h000002);
    check("t3_acks", ack_cnt, 2);
    check("t3_byte_cnt", byte_cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("t3_byte%0d", i), {24'd0, byte_q[i]}, {24'd0, exp3[i]});
      check($sformatf("t3_last%0d", i), {31'd0, last_q[i]}, (i == 5) ? 1 : 0);
    end

    // 4: random backpressure
    clear_logs();
    rand_ready = 1'b1;
    do_start(24'h000040, 16'd8);
    wait_idle("t4_timeout", 4000);
    rand_ready = 1'b0;
    check("t4_byte_cnt", byte_cnt, 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_byte%0d", i), {24'd0, byte_q[i]}, 32'h40 + i);
      check($sformatf("t4_last%0d", i), {31'd0, last_q[i]}, (i == 7) ? 1 : 0);
    end
    check("t4_stable", stab_err, 0);
    check("t4_addr_cnt", addr_cnt, 2);
    check("t4_second_addr_after4", bytes_at_addr[1], 4);
    check("t4_flight", flight_err, 0);

    // 5a: abort while waiting for the word
    clear_logs();
    do_start(24'h000200, 16'd8);
    n = 0;
    while (addr_cnt == 0 && n < 500) begin
      tick();
      n++;
    end
    check("t5a_addr_seen", addr_cnt, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5a_still_busy", {31'd0, busy}, 1);
    check("t5a_no_early_done", done_cnt, 0);
    wait_idle("t5a_timeout", 500);
    check("t5a_acks", ack_cnt, 1);
    check("t5a_done_cnt", done_cnt, 1);
    check("t5a_bytes", byte_cnt, 0);
    check("t5a_addr_cnt", addr_cnt, 1);

    // 5b: abort while draining
    clear_logs();
    ready_fixed = 1'b0;
    do_start(24'h000300, 16'd8);
    wait_valid("t5b_valid_timeout", 500);
    abort = 1'b1;
    #1;
    check("t5b_valid_dropped", {31'd0, out_valid}, 0);
    tick();
    abort = 1'b0;
    check("t5b_done_next", {31'd0, done}, 1);
    tick();
    check("t5b_idle", {31'd0, busy}, 0);
    ready_fixed = 1'b1;
    repeat (50) tick();
    check("t5b_addr_cnt", addr_cnt, 1);
    check("t5b_bytes", byte_cnt, 0);
    check("t5b_done_cnt", done_cnt, 1);

    // 5c: normal transfer after aborts
    clear_logs();
    do_start(24'h000020, 16'd3);
    wait_idle("t5c_timeout", 1000);
    check("t5c_byte_cnt", byte_cnt, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5c_byte%0d", i), {24'd0, byte_q[i]}, 32'h20 + i);
      check($sformatf("t5c_last%0d", i), {31'd0, last_q[i]}, (i == 2) ? 1 : 0);
    end
    check("t5c_acks", ack_cnt, 1);

    // 6a: start while busy is ignored
    clear_logs();
    do_start(24'h000500, 16'd4);
    tick();
    do_start(24'h000600, 16'd2);
    wait_idle("t6a_timeout", 1000);
    check("t6a_addr_cnt", addr_cnt, 1);
    check("t6a_addr0", {8'd0, addr_q[0]}, 32'h000500);
    check("t6a_byte_cnt", byte_cnt, 4);
    check("t6a_byte3", {24'd0, byte_q[3]}, 32'h03);
    check("t6a_done_cnt", done_cnt, 1);

    // 6b: reset mid-drain
    clear_logs();
    ready_fixed = 1'b0;
    do_start(24'h000700, 16'd8);
    wait_valid("t6b_valid_timeout", 500);
    reset = 1'b1;
    #1;
    check("t6b_busy", {31'd0, busy}, 0);
    check("t6b_out_valid", {31'd0, out_valid}, 0);
    check("t6b_out_data", {24'd0, out_data}, 0);
    check("t6b_addr_data", {8'd0, spi_addr_data}, 0);
    check("t6b_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b0;
    ready_fixed = 1'b1;
    repeat (60) tick();
    check("t6b_no_done", done_cnt, 0);
    check("t6b_no_bytes", byte_cnt, 0);
    check("t6b_idle", {31'd0, busy}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
